inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
// - Byte-stream program loader: writer side of the instruction RAM's write port (we/addr/di).
// - Takes bytes from the UART receiver via a valid/ready handshake and assembles them into
//   little-endian 32-bit words. Writes each word to consecutive instruction-memory addresses.
// - Holds the core in reset (busy) until the image is in; then flags done.
// PARAMETERS
// - ADDR_W     10    instruction-memory address width
// - DEPTH      1024  instruction-memory words
// - BASE_ADDR  0     address of the first word written
// PORTS
// - clk       in   1       clock
// - rst       in   1       synchronous reset, active-high
// - rx_valid  in   1       byte available from UART receiver
// - rx_data   in   8       received byte
// - rx_ready  out  1       loader accepts byte this cycle
// - start     in   1       one-cycle pulse: re-arm the loader from DONE/ERR
// - mem_we    out  1       write strobe to instruction RAM
// - mem_addr  out  ADDR_W  write address
// - mem_di    out  32      write data
// - busy      out  1       loading in progress (LEN/DATA/CHK)
// - done      out  1       image loaded successfully (level)
// - err       out  1       bad length or checksum (level)
// - word_cnt  out  ADDR_W+1  words written so far
// BEHAVIOUR
// - Reset: state=LEN. rx_ready=1, busy=1, mem_we=0, mem_addr=0, mem_di=0, done=0, err=0,
//   word_cnt=0. Byte index=0. Any partial word is discarded.
// - A byte is accepted when rx_valid && rx_ready. rx_ready=1 only in LEN, DATA and CHK.
// - Stream format:
//   - 4 bytes: word count N, little-endian (LSB first).
//   - N*4 bytes: words, each LSB first.
//   - [1 checksum byte, only with the option below].
// - States:
//   - LEN: collect 4 bytes into N. On the 4th byte:
//     - N > DEPTH-BASE_ADDR -> ERR.
//     - N == 0 -> DONE (or CHK when the option is enabled).
//     - otherwise -> DATA.
//   - DATA: shift bytes into the word register. On the 4th byte the word is complete:
//     - next cycle: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+word_cnt
//       (truncated to ADDR_W), mem_di=assembled word. word_cnt increments in that same cycle.
//     - latency: 1 cycle from the 4th-byte accept to mem_we.
//     - after the N-th word -> DONE (or CHK). rx_ready stays high, so back-to-back bytes are
//       accepted every cycle.
//   - DONE: done=1, busy=0, rx_ready=0. Incoming bytes are left unaccepted.
//   - ERR: err=1, busy=0, rx_ready=0. No further writes.
//   - DONE/ERR + start -> LEN. Clears done, err, word_cnt and byte index.
//     start in LEN/DATA/CHK is ignored.
// - mem_addr and mem_di hold their last values when mem_we=0.
// - No write is ever issued outside [BASE_ADDR, BASE_ADDR+N-1]; the length check guarantees
//   no address wrap.
// - rst mid-word or mid-image: abort immediately to the reset state. RAM contents already
//   written are left as they are. No mem_we is issued in the reset cycle or the next one.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - after the last word (or N==0) the state is CHK; one more byte is accepted.
//   - the expected byte is the XOR of all data bytes (length bytes excluded; 8'h00 when N==0).
//   - match -> DONE; mismatch -> ERR (words already written stay in RAM).
// - LOADER_CHECKSUM_EN undefined: there is no CHK state and no checksum logic; the last word
//   goes straight to DONE.
// TESTING
// - rst, stream 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 ->
//   - mem_we pulses at addr 0 with 32'h00000013, then at addr 1 with 32'h0000006F.
//   - then done=1, word_cnt=2.
// - length 00 04 00 00 (1024) with BASE_ADDR=0 -> accepted. Length 01 04 00 00 (1025) ->
//   err=1 after the 4th byte, no mem_we ever.
// - length 0 -> done=1 with no mem_we (checksum build: after a further byte 00).
// - rx_valid held high continuously with one byte per cycle -> rx_ready never drops in DATA.
//   mem_we occurs every 4 cycles, each 1 cycle after the 4th byte of its word.
// - rst asserted after 2 of 4 bytes of word 3 -> no write for word 3. After re-sending the full
//   image, words 0.. are written starting again at addr 0.
// - LOADER_CHECKSUM_EN, one word DE AD BE EF:
//   - trailing 0x22 (DE^AD^BE^EF) -> done=1.
//   - trailing 0x23 -> err=1, RAM[0]=32'hEFBEADDE.
//   - then start -> state LEN, err=0.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-in / word-out bus of the program loader: UART byte handshake on one
// side, instruction-RAM write port on the other.
interface inst_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_di;

  // master: the loader (takes bytes, drives RAM writes)
  modport master (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_di);
  // slave: the UART/RAM side seen from outside the loader
  modport slave  (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_di);
endinterface

// File: rtl/inst_loader.sv
// Program loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words and writes them to consecutive instruction-RAM addresses.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_loader #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  inst_loader_if.master     bus,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [1:0]        bidx;      // byte position within the current 4-byte group
  logic [23:0]       len_sh;    // first three length bytes, LSB-first shift
  logic [ADDR_W:0]   len_q;     // checked word count N
  logic [23:0]       wbuf;      // first three bytes of the word in flight
  logic [31:0]       len_full;
  logic [ADDR_W:0]   cnt_nxt;
  logic              rdy, acc, last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Ready/busy/done/err are pure functions of the state, so they never
  // depend combinationally on rx_valid.
`ifdef LOADER_CHECKSUM_EN
  assign rdy = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign rdy = (state_q == S_LEN) || (state_q == S_DATA);
`endif
  assign bus.rx_ready = rdy;
  assign busy         = rdy;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);

  assign acc       = bus.rx_valid && rdy;
  assign last_byte = (bidx == 2'd3);
  assign len_full  = {bus.rx_data, len_sh};
  assign cnt_nxt   = word_cnt + {{ADDR_W{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LEN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: if (acc && last_byte) begin
        // Length is checked in full 32 bits so huge N cannot alias into range.
        if (len_full > 32'(DEPTH - BASE_ADDR)) state_d = S_ERR;
        else if (len_full == 32'd0)            state_d = S_END;
        else                                   state_d = S_DATA;
      end
      S_DATA: if (acc && last_byte && (cnt_nxt == len_q)) state_d = S_END;
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (acc) state_d = (bus.rx_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE: if (start) state_d = S_LEN;
      S_ERR:  if (start) state_d = S_LEN;
      default: state_d = S_LEN;
    endcase
  end

  // Byte assembly and the registered RAM write (one cycle after the 4th byte)
  always_ff @(posedge clk) begin
    if (rst) begin
      bidx         <= 2'd0;
      len_sh       <= '0;
      len_q        <= '0;
      wbuf         <= '0;
      word_cnt     <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_di   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      if ((state_q == S_DONE || state_q == S_ERR) && start) begin
        bidx     <= 2'd0;
        word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (acc) begin
        bidx <= bidx + 2'd1;
        if (state_q == S_LEN) begin
          len_sh <= {bus.rx_data, len_sh[23:8]};
          if (last_byte) len_q <= len_full[ADDR_W:0];
        end else if (state_q == S_DATA) begin
          wbuf <= {bus.rx_data, wbuf[23:8]};
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ bus.rx_data;
`endif
          if (last_byte) begin
            // Capture the word separately so the next word can start
            // shifting in on the very next cycle.
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= ADDR_W'(BASE_ADDR) + word_cnt[ADDR_W-1:0];
            bus.mem_di   <= {bus.rx_data, wbuf};
            word_cnt     <= cnt_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed streams push expected RAM
// writes (address, data, bytes accepted so far); a monitor pops and checks
// every mem_we pulse.
module tb_inst_loader;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;
  logic [ADDR_W:0] word_cnt;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          nacc;   // bytes accepted since reset/start when the write shows
  } wr_t;

  wr_t  sb[$];
  wr_t  mon_e;
  logic [7:0] byte_q[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic exp_w(input int a, input logic [31:0] d, input int n);
    wr_t e;
    e.addr = a; e.data = d; e.nacc = n;
    sb.push_back(e);
  endtask

  // Sends byte_q; b2b holds rx_valid high and requires a byte every cycle.
  task automatic send_q(input bit b2b);
    for (int i = 0; i < byte_q.size(); i++) begin
      int w;
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = byte_q[i];
      w = 0;
      while (!bus.rx_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w == 50) begin
        ncmp++; nerr++;
        $display("FAIL accept_timeout: byte %0d not accepted within 50 cycles", i);
        bus.rx_valid = 1'b0;
        return;
      end
      if (b2b) chk("b2b_ready_stall", w, 0);
      @(posedge clk);
      if (!b2b) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Bytes accepted, counted the same way the stream description counts them
  always @(posedge clk) begin
    if (rst || start)                     acc_cnt <= 0;
    else if (bus.rx_valid && bus.rx_ready) acc_cnt <= acc_cnt + 1;
  end

  // Monitor: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.mem_addr, bus.mem_di);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        chk("wr_data", bus.mem_di, mon_e.data);
        chk("wr_latency_bytes", acc_cnt, mon_e.nacc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_rx_ready", bus.rx_ready, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_di", bus.mem_di, 0);

    // Two-word image with idle gaps between bytes
    byte_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    byte_q.push_back(8'h7C);
`endif
    exp_w(0, 32'h00000013, 8);
    exp_w(1, 32'h0000006F, 12);
    send_q(1'b0);
    repeat (2) @(negedge clk);
    chk("img2_done", done, 1);
    chk("img2_busy", busy, 0);
    chk("img2_word_cnt", word_cnt, 2);
    chk("img2_err", err, 0);
    chk("hold_mem_addr", bus.mem_addr, 1);
    chk("hold_mem_di", bus.mem_di, 32'h0000006F);

    // DONE leaves incoming bytes unaccepted
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("done_rx_ready", bus.rx_ready, 0);
    chk("done_ignores_bytes", acc_cnt, 12 + (sb.size() * 0) + ((byte_q.size() > 12) ? 1 : 0));
    bus.rx_valid = 1'b0;

    // Length 1025 is out of range
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_word_cnt", word_cnt, 0);
    byte_q = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_q(1'b0);
    chk("len1025_err", err, 1);
    chk("len1025_busy", busy, 0);
    chk("len1025_rx_ready", bus.rx_ready, 0);
    chk("len1025_done", done, 0);

    // Length zero
    pulse_start();
    chk("start_err_clr", err, 0);
    byte_q = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    byte_q.push_back(8'h00);
`endif
    send_q(1'b0);
    chk("len0_done", done, 1);
    chk("len0_word_cnt", word_cnt, 0);

    // Back-to-back three-word image: one byte per cycle, write every 4 cycles
    pulse_start();
    byte_q = '{8'h03, 8'h00, 8'h00, 8'h00,
               8'h44, 8'h33, 8'h22, 8'h11,
               8'hDD, 8'hCC, 8'hBB, 8'hAA,
               8'h04, 8'h03, 8'h02, 8'h01};
`ifdef LOADER_CHECKSUM_EN
    byte_q.push_back(8'h40);
`endif
    exp_w(0, 32'h11223344, 8);
    exp_w(1, 32'hAABBCCDD, 12);
    exp_w(2, 32'h01020304, 16);
    send_q(1'b1);
    chk("b2b_done", done, 1);
    chk("b2b_word_cnt", word_cnt, 3);

    // Length 1024 is accepted; reset after 2 bytes of word 3
    pulse_start();
    byte_q = '{8'h00, 8'h04, 8'h00, 8'h00,
               8'h10, 8'h00, 8'h00, 8'h00,
               8'h20, 8'h00, 8'h00, 8'h00,
               8'h30, 8'h00, 8'h00, 8'h00,
               8'h40, 8'h41};
    exp_w(0, 32'h00000010, 8);
    exp_w(1, 32'h00000020, 12);
    exp_w(2, 32'h00000030, 16);
    send_q(1'b0);
    chk("len1024_err", err, 0);
    chk("len1024_busy", busy, 1);
    chk("len1024_word_cnt", word_cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_rx_ready", bus.rx_ready, 1);

    // Re-sent image restarts at address 0
    byte_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    byte_q.push_back(8'h7C);
`endif
    exp_w(0, 32'h00000013, 8);
    exp_w(1, 32'h0000006F, 12);
    send_q(1'b1);
    chk("resend_done", done, 1);
    chk("resend_word_cnt", word_cnt, 2);

    // One word DE AD BE EF
    pulse_start();
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
    byte_q.push_back(8'h23);
`endif
    exp_w(0, 32'hEFBEADDE, 8);
    send_q(1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_bad_err", err, 1);
    chk("csum_bad_done", done, 0);
    pulse_start();
    chk("csum_start_err", err, 0);
    chk("csum_start_busy", busy, 1);
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    exp_w(0, 32'hEFBEADDE, 8);
    send_q(1'b0);
    chk("csum_good_done", done, 1);
    chk("csum_good_err", err, 0);
`else
    chk("one_word_done", done, 1);
    chk("one_word_err", err, 0);
`endif
    chk("one_word_cnt", word_cnt, 1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
